otter_mem_responder: RTL and testbench
======================================

OTTER_MEM_RESPONDER -- requirements
Module: otter_mem_responder

Interface
REQ-001 The block SHALL have these ports; clock and reset are listed first:
- clk  in  1  single clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- memRDEN1  in  1  instruction-fetch read strobe.
- memAddr1  in  32  fetch byte address.
- memRDEN2  in  1  data read strobe.
- memWE2  in  1  data write strobe.
- memAddr2  in  32  data byte address.
- memDin2  in  32  store data, right-justified.
- memSize  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- memSign  in  1  read extension: 0 sign-extend, 1 zero-extend.
- errClr  in  1  clears err.
- IO_IN  in  32  MMIO read data.
- memDout1  out  32  fetch data.
- valid1  out  1  memDout1 updated this cycle.
- memDout2  out  32  load data, extended to 32 bits.
- valid2  out  1  memDout2 updated this cycle.
- IO_WR  out  1  MMIO write pulse.
- IO_ADDR  out  32  MMIO address.
- IO_DATA  out  32  MMIO write data.
- err  out  1  sticky access-error flag.

Function
REQ-002 The block SHALL contain 16384 x 32-bit words of RAM, mapped at byte addresses 0x0000_0000-0x0000_FFFF and indexed by addr[15:2].
REQ-003 Port-2 addresses >= 0x1100_0000 SHALL be MMIO; all other unmapped addresses SHALL be errors.
REQ-004 Fetch: on an edge with memRDEN1=1, the block SHALL load memDout1 with mem[memAddr1[15:2]] and pulse valid1 high for exactly one cycle.
REQ-005 memDout1 SHALL hold its value while memRDEN1=0.
REQ-006 A fetch with memAddr1[1:0]!=0 or an unmapped memAddr1 SHALL load memDout1=0, pulse valid1, and set err.
REQ-007 Load: on an edge with memRDEN2=1, the block SHALL select the byte or half at offset addr[1:0], extend it per memSign, load memDout2, and pulse valid2 for one cycle. Latency is 1 cycle.
REQ-008 A store SHALL write only the addressed byte lanes:
- byte: lane addr[1:0] <- memDin2[7:0]
- half: lanes addr[1]*2+{0,1} <- memDin2[15:0]
- word: all lanes <- memDin2.
REQ-009 Misalignment SHALL be: half with addr[0]=1; word with addr[1:0]!=0; or memSize=11.
REQ-010 A misaligned or unmapped port-2 access SHALL not write, SHALL return memDout2=0 with valid2 pulsed if it was a read, and SHALL set err.
REQ-011 An MMIO read SHALL register IO_IN as a full word, ignoring memSize and memSign, with valid2 pulsed.
REQ-012 An MMIO write SHALL not touch RAM; on the following cycle IO_WR=1 for one cycle, with IO_ADDR=memAddr2 and IO_DATA=memDin2 as registered at the strobe edge.
REQ-013 IO_ADDR and IO_DATA SHALL hold until the next MMIO write.
REQ-014 When memRDEN2 and memWE2 are both 1, the write SHALL be performed, the read suppressed (valid2 stays 0), and err set.
REQ-015 When a fetch and a store hit the same word on the same edge, memDout1 SHALL return the pre-write data (read-before-write).
REQ-016 A load on the edge following a store to the same word SHALL return the new data.
REQ-017 err SHALL be set by any error and cleared on an edge with errClr=1. A simultaneous new error SHALL take priority, leaving err=1.
REQ-018 Strobes are single-cycle. A strobe held high SHALL be serviced again on every edge.

Reset
REQ-019 While RST_N=0, memDout1, memDout2, valid1, valid2, IO_WR, IO_ADDR, IO_DATA and err SHALL be 0, asynchronously and without waiting for clk.
REQ-020 RAM contents SHALL be unaffected by reset.
REQ-021 An access in flight when RST_N falls SHALL be discarded, with no valid or IO_WR pulse after release.
REQ-022 The first access after release SHALL be accepted on the first rising edge with RST_N=1.

Verification
REQ-023 Sign/zero extension: sw 0xDEADBEEF @0x100, then
- lb @0x101 -> memDout2=0xFFFFFFBE
- lbu @0x101 -> 0x000000BE
- lh @0x102 -> 0xFFFFDEAD
- each with valid2 high for 1 cycle.
REQ-024 Byte-lane write and port collision:
- sb 0x55 @0x103, then lw @0x100 -> 0x55ADBEEF.
- Same-edge fetch @0x100 and sw 0x0 @0x100 -> memDout1=0x55ADBEEF.
REQ-025 MMIO write: sw 0x12 @0x11000004 -> next cycle IO_WR=1 for 1 cycle, IO_ADDR=0x11000004, IO_DATA=0x00000012; RAM word 0x0004 unchanged.
REQ-026 Error handling:
- lw @0x102 -> memDout2=0, valid2=1, err=1.
- err stays 1 until errClr=1.
- errClr together with a misaligned sh -> err remains 1.
REQ-027 Reset mid-operation: assert RST_N=0 mid-cycle during a valid2 pulse -> all outputs 0 immediately. After release, lw @0x100 -> 0x55ADBEEF.

Source files
------------

// File: rtl/otter_mem_responder.sv
// Dual-port OTTER memory: 64 KiB word RAM with a fetch port, a load/store port and MMIO.
// Both ports have single-cycle registered responses, and a sticky error flag collects faults.
module otter_mem_responder (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        memRDEN1,
  input  logic [31:0] memAddr1,
  input  logic        memRDEN2,
  input  logic        memWE2,
  input  logic [31:0] memAddr2,
  input  logic [31:0] memDin2,
  input  logic [1:0]  memSize,
  input  logic        memSign,
  input  logic        errClr,
  input  logic [31:0] IO_IN,
  output logic [31:0] memDout1,
  output logic        valid1,
  output logic [31:0] memDout2,
  output logic        valid2,
  output logic        IO_WR,
  output logic [31:0] IO_ADDR,
  output logic [31:0] IO_DATA,
  output logic        err
);

  localparam logic [31:0] MMIO_BASE = 32'h1100_0000;

  logic [31:0] mem [0:16383];

  logic        f_err;
  logic        a_ram, a_mmio, mis, p2_bad, coll, new_err;
  logic        ram_wr, io_wr_now, do_rd;
  logic [31:0] rd_word, ld_val, lane_wd;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;
  logic [3:0]  lane_we;

  always_comb begin
    f_err     = memRDEN1 & ((memAddr1[31:16] != 16'h0) | (memAddr1[1:0] != 2'b00));
    a_ram     = (memAddr2[31:16] == 16'h0);
    a_mmio    = (memAddr2 >= MMIO_BASE);

    mis = 1'b0;
    case (memSize)
      2'b00:   mis = 1'b0;
      2'b01:   mis = memAddr2[0];
      2'b10:   mis = |memAddr2[1:0];
      default: mis = 1'b1;
    endcase

    // MMIO is a full-word window, so size/alignment only matter for RAM
    p2_bad    = ~a_mmio & (~a_ram | mis);
    coll      = memRDEN2 & memWE2;
    new_err   = f_err | ((memRDEN2 | memWE2) & p2_bad) | coll;
    ram_wr    = memWE2 & a_ram & ~mis;
    io_wr_now = memWE2 & a_mmio;
    do_rd     = memRDEN2 & ~memWE2;

    rd_word = mem[memAddr2[15:2]];
    sel_b   = rd_word[7:0];
    case (memAddr2[1:0])
      2'b00: sel_b = rd_word[7:0];
      2'b01: sel_b = rd_word[15:8];
      2'b10: sel_b = rd_word[23:16];
      2'b11: sel_b = rd_word[31:24];
    endcase
    sel_h = memAddr2[1] ? rd_word[31:16] : rd_word[15:0];

    ld_val = rd_word;
    case (memSize)
      2'b00:   ld_val = {{24{~memSign & sel_b[7]}}, sel_b};
      2'b01:   ld_val = {{16{~memSign & sel_h[15]}}, sel_h};
      default: ld_val = rd_word;
    endcase

    lane_we = 4'b1111;
    lane_wd = memDin2;
    case (memSize)
      2'b00: begin
        lane_we = 4'b0001 << memAddr2[1:0];
        lane_wd = {4{memDin2[7:0]}};
      end
      2'b01: begin
        lane_we = memAddr2[1] ? 4'b1100 : 4'b0011;
        lane_wd = {2{memDin2[15:0]}};
      end
      default: begin
        lane_we = 4'b1111;
        lane_wd = memDin2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_we[i[1:0]])
          mem[memAddr2[15:2]][{i[1:0], 3'b000} +: 8] <= lane_wd[{i[1:0], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      memDout1 <= '0;
      valid1   <= 1'b0;
      memDout2 <= '0;
      valid2   <= 1'b0;
      IO_WR    <= 1'b0;
      IO_ADDR  <= '0;
      IO_DATA  <= '0;
      err      <= 1'b0;
    end else begin
      valid1 <= memRDEN1;
      if (memRDEN1)
        memDout1 <= f_err ? '0 : mem[memAddr1[15:2]];

      valid2 <= do_rd;
      if (do_rd)
        memDout2 <= p2_bad ? '0 : (a_mmio ? IO_IN : ld_val);

      IO_WR <= io_wr_now;
      if (io_wr_now) begin
        IO_ADDR <= memAddr2;
        IO_DATA <= memDin2;
      end

      // a fresh fault outranks a clear on the same edge
      if (new_err)
        err <= 1'b1;
      else if (errClr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_otter_mem_responder.sv
// Scoreboard bench for otter_mem_responder: loads push expected data,
// and a negedge monitor pops and compares whenever valid2 pulses.
module tb_otter_mem_responder;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        memRDEN1, memRDEN2, memWE2, memSign, errClr;
  logic [31:0] memAddr1, memAddr2, memDin2, IO_IN;
  logic [1:0]  memSize;
  logic [31:0] memDout1, memDout2, IO_ADDR, IO_DATA;
  logic        valid1, valid2, IO_WR, err;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  otter_mem_responder dut (
    .clk(clk), .RST_N(RST_N),
    .memRDEN1(memRDEN1), .memAddr1(memAddr1),
    .memRDEN2(memRDEN2), .memWE2(memWE2), .memAddr2(memAddr2), .memDin2(memDin2),
    .memSize(memSize), .memSign(memSign), .errClr(errClr), .IO_IN(IO_IN),
    .memDout1(memDout1), .valid1(valid1), .memDout2(memDout2), .valid2(valid2),
    .IO_WR(IO_WR), .IO_ADDR(IO_ADDR), .IO_DATA(IO_DATA), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (RST_N && valid2) begin
      if (exp_q.size() == 0)
        check("valid2_unexpected", {31'b0, valid2}, 32'h0);
      else
        check("load_data", memDout2, exp_q.pop_front());
    end
  end

  task automatic p2(input logic rd, input logic wr, input logic [31:0] addr,
                    input logic [31:0] din, input logic [1:0] size, input logic sgn);
    memRDEN2 = rd; memWE2 = wr; memAddr2 = addr; memDin2 = din;
    memSize = size; memSign = sgn;
    @(posedge clk); #1;
    memRDEN2 = 1'b0; memWE2 = 1'b0;
  endtask

  task automatic ld(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                    input logic [31:0] exp);
    exp_q.push_back(exp);
    p2(1'b1, 1'b0, addr, 32'h0, size, sgn);
  endtask

  task automatic st(input logic [31:0] addr, input logic [31:0] din, input logic [1:0] size);
    p2(1'b0, 1'b1, addr, din, size, 1'b0);
  endtask

  task automatic clr_err();
    errClr = 1'b1;
    @(posedge clk); #1;
    errClr = 1'b0;
    check("err_cleared", {31'b0, err}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout1"}, memDout1, 32'h0);
    check({tag, "_dout2"}, memDout2, 32'h0);
    check({tag, "_ioaddr"}, IO_ADDR, 32'h0);
    check({tag, "_iodata"}, IO_DATA, 32'h0);
    check({tag, "_flags"}, {27'b0, valid1, valid2, IO_WR, err, 1'b0}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N = 1'b1;
    memRDEN1 = 0; memRDEN2 = 0; memWE2 = 0; memSign = 0; errClr = 0;
    memAddr1 = 0; memAddr2 = 0; memDin2 = 0; memSize = 2'b10; IO_IN = 0;

    #2 RST_N = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 RST_N = 1'b1;

    // extension cases
    st(32'h100, 32'hDEADBEEF, 2'b10);
    ld(32'h101, 2'b00, 1'b0, 32'hFFFFFFBE);
    ld(32'h101, 2'b00, 1'b1, 32'h000000BE);
    ld(32'h102, 2'b01, 1'b0, 32'hFFFFDEAD);
    ld(32'h102, 2'b01, 1'b1, 32'h0000DEAD);
    ld(32'h100, 2'b00, 1'b0, 32'hFFFFFFEF);
    ld(32'h103, 2'b00, 1'b1, 32'h000000DE);

    // byte and half lane writes, load right after store
    st(32'h103, 32'hAAAA_AA55, 2'b00);
    ld(32'h100, 2'b10, 1'b0, 32'h55ADBEEF);
    st(32'h104, 32'hAABBCCDD, 2'b10);
    st(32'h106, 32'hFFFF1234, 2'b01);
    ld(32'h104, 2'b10, 1'b0, 32'h1234CCDD);
    check("err_clean", {31'b0, err}, 32'h0);

    // fetch path
    memRDEN1 = 1'b1; memAddr1 = 32'h104;
    @(posedge clk); #1 memRDEN1 = 1'b0;
    check("fetch_valid", {31'b0, valid1}, 32'h1);
    check("fetch_data", memDout1, 32'h1234CCDD);

    // same-edge fetch and store: read-before-write
    memRDEN1 = 1'b1; memAddr1 = 32'h100;
    memWE2 = 1'b1; memAddr2 = 32'h100; memDin2 = 32'h0; memSize = 2'b10;
    @(posedge clk); #1;
    memRDEN1 = 1'b0; memWE2 = 1'b0;
    check("coll_valid1", {31'b0, valid1}, 32'h1);
    check("coll_dout1", memDout1, 32'h55ADBEEF);
    @(posedge clk); #1;
    check("valid1_pulse", {31'b0, valid1}, 32'h0);
    check("dout1_hold", memDout1, 32'h55ADBEEF);
    ld(32'h100, 2'b10, 1'b0, 32'h0);
    st(32'h100, 32'h55ADBEEF, 2'b10);

    // MMIO write leaves RAM alone
    st(32'h4, 32'h0BADF00D, 2'b10);
    st(32'h11000004, 32'h12, 2'b10);
    check("io_wr_pulse", {31'b0, IO_WR}, 32'h1);
    check("io_addr", IO_ADDR, 32'h11000004);
    check("io_data", IO_DATA, 32'h12);
    @(posedge clk); #1;
    check("io_wr_end", {31'b0, IO_WR}, 32'h0);
    check("io_addr_hold", IO_ADDR, 32'h11000004);
    check("io_data_hold", IO_DATA, 32'h12);
    ld(32'h4, 2'b10, 1'b0, 32'h0BADF00D);

    // MMIO read ignores size/sign
    IO_IN = 32'hCAFEF00D;
    ld(32'h11000000, 2'b00, 1'b0, 32'hCAFEF00D);
    check("err_clean2", {31'b0, err}, 32'h0);

    // errors
    ld(32'h102, 2'b10, 1'b0, 32'h0);
    check("err_misaligned_lw", {31'b0, err}, 32'h1);
    repeat (3) @(posedge clk);
    #1 check("err_sticky", {31'b0, err}, 32'h1);
    clr_err();
    errClr = 1'b1;
    st(32'h101, 32'hFFFF, 2'b01);
    errClr = 1'b0;
    check("err_clr_vs_new", {31'b0, err}, 32'h1);
    ld(32'h100, 2'b10, 1'b0, 32'h55ADBEEF);
    clr_err();
    ld(32'h20000, 2'b10, 1'b0, 32'h0);
    check("err_unmapped", {31'b0, err}, 32'h1);
    clr_err();
    st(32'h108, 32'h1, 2'b11);
    check("err_size11", {31'b0, err}, 32'h1);
    clr_err();

    memRDEN1 = 1'b1; memAddr1 = 32'h102;
    @(posedge clk); #1 memRDEN1 = 1'b0;
    check("fetch_mis_valid", {31'b0, valid1}, 32'h1);
    check("fetch_mis_data", memDout1, 32'h0);
    check("fetch_mis_err", {31'b0, err}, 32'h1);
    clr_err();

    // read+write together: write wins, no valid2
    p2(1'b1, 1'b1, 32'h200, 32'h77, 2'b10, 1'b0);
    check("rw_err", {31'b0, err}, 32'h1);
    ld(32'h200, 2'b10, 1'b0, 32'h77);
    clr_err();

    // held strobe serviced each edge
    memRDEN2 = 1'b1; memWE2 = 1'b0; memAddr2 = 32'h104; memSize = 2'b10;
    repeat (3) exp_q.push_back(32'h1234CCDD);
    repeat (3) @(posedge clk);
    #1 memRDEN2 = 1'b0;

    // reset during a valid2 pulse
    memRDEN2 = 1'b1; memAddr2 = 32'h100; memSize = 2'b10;
    @(posedge clk); #1 memRDEN2 = 1'b0;
    check("pre_rst_valid2", {31'b0, valid2}, 32'h1);
    check("pre_rst_dout2", memDout2, 32'h55ADBEEF);
    RST_N = 1'b0;
    #1 check_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 RST_N = 1'b1;
    @(negedge clk);
    check("post_rst_quiet", {29'b0, valid1, valid2, IO_WR}, 32'h0);
    ld(32'h100, 2'b10, 1'b0, 32'h55ADBEEF);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
